// File: rtl/ib_lut_pkg.sv
// Shared types and constants for the CN IB-LUT ping-pong loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ib_lut_pkg;

    // Default magnitude width of one LUT entry (QUAN_SIZE-1)
    localparam int LUT_PORT_SIZE_DEF   = 2;
    // Default LUT address width including the frame-offset bits
    localparam int ENTRY_ADDR_DEF      = 4;
    // Two halves: one read by the CNUs, one being refilled
    localparam int MULTI_FRAME_NUM_DEF = 2;

    // Page address width once the half-select bits are removed
    function automatic int page_w(input int entry_addr, input int multi_frame_num);
        return entry_addr - $clog2(multi_frame_num);
    endfunction

    localparam int PAGE_W_DEF   = page_w(ENTRY_ADDR_DEF, MULTI_FRAME_NUM_DEF);
    localparam int PAGE_NUM_DEF = 2 ** PAGE_W_DEF;

    // Loader FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_SWAP  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/ib_lut_page_cnt.sv
// Page counter for the loader: clear, increment, and a flag on the final page.
// Latency: count updates one cycle after clr/inc; last is combinational from the count.
// Backpressure: none; saturates at the final page rather than wrapping.
module ib_lut_page_cnt #(
    parameter int PAGE_W = 3
) (
    input  logic              write_clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              inc,
    output logic [PAGE_W-1:0] cnt,
    output logic              last
);

    assign last = (cnt == {PAGE_W{1'b1}});

    // Clear has priority; increment stops at the last page so it never wraps
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ib_cn_lut_load_ctrl.sv
// Ping-pong loader for the symmetric CN IB-LUT; optional checksum via IB_LUT_LOAD_CHKSUM_EN.
// Latency: LUT write issues exactly 1 cycle after a beat is accepted; swap 1 cycle after READY sees a request.
// Backpressure: in_ready is high only while loading; upstream holds beats otherwise.
module ib_cn_lut_load_ctrl
    import ib_lut_pkg::*;
#(
    parameter int LUT_PORT_SIZE   = LUT_PORT_SIZE_DEF,
    parameter int ENTRY_ADDR      = ENTRY_ADDR_DEF,
    parameter int MULTI_FRAME_NUM = MULTI_FRAME_NUM_DEF,
    localparam int PAGE_W         = page_w(ENTRY_ADDR, MULTI_FRAME_NUM)
) (
    input  logic                       write_clk,
    input  logic                       rstn,
    input  logic                       load_start,
    input  logic                       load_abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*LUT_PORT_SIZE-1:0] in_data,
`ifdef IB_LUT_LOAD_CHKSUM_EN
    input  logic [2*LUT_PORT_SIZE-1:0] chk_data,
`endif
    input  logic                       swap_req,
    output logic [LUT_PORT_SIZE-1:0]   lut_in_bank0,
    output logic [LUT_PORT_SIZE-1:0]   lut_in_bank1,
    output logic [PAGE_W-1:0]          page_write_addr,
    output logic                       write_addr_offset,
    output logic                       we,
    output logic                       read_addr_offset,
    output logic                       swap_done,
    output logic                       shadow_ready,
    output logic                       load_err
);

    ld_state_e         state;
    ld_state_e         state_nxt;
    logic              swap_pending;
    logic [PAGE_W-1:0] page_cnt;
    logic              page_last;
    logic              accept;
    logic              start_ok;
    logic              abort_ok;
    logic              last_beat;
    logic              swap_go;
    logic              chk_ok;

    assign in_ready          = (state == ST_LOAD);
    assign shadow_ready      = (state == ST_READY);
    assign swap_done         = (state == ST_SWAP);
    // The written half is always the one the CNUs are not reading
    assign write_addr_offset = ~read_addr_offset;

    assign accept    = in_valid & in_ready;
    assign start_ok  = (state == ST_IDLE) & load_start;
    assign abort_ok  = (state == ST_LOAD) & load_abort;
    assign last_beat = accept & page_last;
    // A request arriving in the READY cycle itself swaps on the next edge
    assign swap_go   = (state == ST_READY) & (swap_pending | swap_req);

    ib_lut_page_cnt #(
        .PAGE_W (PAGE_W)
    ) u_page_cnt (
        .write_clk (write_clk),
        .rstn      (rstn),
        .clr       (start_ok),
        .inc       (accept),
        .cnt       (page_cnt),
        .last      (page_last)
    );

`ifdef IB_LUT_LOAD_CHKSUM_EN
    logic [2*LUT_PORT_SIZE-1:0] chk_acc;

    // The final beat is folded in combinationally so it is checked in its own accept cycle
    assign chk_ok = ((chk_acc ^ in_data) == chk_data);

    // Running XOR of accepted beats plus a sticky error flag, both reset by a new load
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            chk_acc  <= '0;
            load_err <= 1'b0;
        end else if (start_ok) begin
            chk_acc  <= '0;
            load_err <= 1'b0;
        end else begin
            if (accept) begin
                chk_acc <= chk_acc ^ in_data;
            end
            if (last_beat && !abort_ok && !chk_ok) begin
                load_err <= 1'b1;
            end
        end
    end
`else
    assign chk_ok   = 1'b1;
    assign load_err = 1'b0;
`endif

    // Next-state: abort wins over a coincident last beat; a bad checksum drops back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_ok) begin
                    state_nxt = ST_IDLE;
                end else if (last_beat) begin
                    state_nxt = chk_ok ? ST_READY : ST_IDLE;
                end
            end
            ST_READY: begin
                if (swap_go) begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and half select; the toggle lands on the edge entering SWAP so swap_done and the new offset coincide
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            read_addr_offset <= 1'b0;
        end else begin
            state <= state_nxt;
            if (swap_go) begin
                read_addr_offset <= ~read_addr_offset;
            end
        end
    end

    // One outstanding swap request at most; the SWAP cycle consumes it
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            swap_pending <= 1'b0;
        end else if (state == ST_SWAP) begin
            swap_pending <= swap_req;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // Write port: registered copy of each accepted beat, strobe for exactly one cycle
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            we              <= 1'b0;
            page_write_addr <= '0;
            lut_in_bank0    <= '0;
            lut_in_bank1    <= '0;
        end else begin
            we <= accept;
            if (accept) begin
                page_write_addr <= page_cnt;
                lut_in_bank0    <= in_data[LUT_PORT_SIZE-1:0];
                lut_in_bank1    <= in_data[2*LUT_PORT_SIZE-1:LUT_PORT_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_ib_cn_lut_load_ctrl.sv
// Bench for the CN IB-LUT ping-pong loader: directed loads, swaps, aborts and reset.
// Latency: n/a.
// Backpressure: stimulus waits on in_ready with a bounded cycle budget.
module tb_ib_cn_lut_load_ctrl;
    import ib_lut_pkg::*;

    localparam int LPS = LUT_PORT_SIZE_DEF;
    localparam int PW  = PAGE_W_DEF;
    localparam int PN  = PAGE_NUM_DEF;

    typedef struct {
        bit         is_swap;
        int         pg;
        int         b0;
        int         b1;
        int         ofs;
        int         gap;
    } exp_t;

    logic             write_clk;
    logic             rstn;
    logic             load_start;
    logic             load_abort;
    logic             in_valid;
    logic             in_ready;
    logic [2*LPS-1:0] in_data;
    logic             swap_req;
    logic [LPS-1:0]   lut_in_bank0;
    logic [LPS-1:0]   lut_in_bank1;
    logic [PW-1:0]    page_write_addr;
    logic             write_addr_offset;
    logic             we;
    logic             read_addr_offset;
    logic             swap_done;
    logic             shadow_ready;
    logic             load_err;
`ifdef IB_LUT_LOAD_CHKSUM_EN
    logic [2*LPS-1:0] chk_data;
    logic [2*LPS-1:0] chk_acc;
    logic             chk_flip;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_we_cyc = -100;
    exp_t exp_q[$];
    exp_t me;

    ib_cn_lut_load_ctrl #(
        .LUT_PORT_SIZE   (LUT_PORT_SIZE_DEF),
        .ENTRY_ADDR      (ENTRY_ADDR_DEF),
        .MULTI_FRAME_NUM (MULTI_FRAME_NUM_DEF)
    ) dut (
        .write_clk         (write_clk),
        .rstn              (rstn),
        .load_start        (load_start),
        .load_abort        (load_abort),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
`ifdef IB_LUT_LOAD_CHKSUM_EN
        .chk_data          (chk_data),
`endif
        .swap_req          (swap_req),
        .lut_in_bank0      (lut_in_bank0),
        .lut_in_bank1      (lut_in_bank1),
        .page_write_addr   (page_write_addr),
        .write_addr_offset (write_addr_offset),
        .we                (we),
        .read_addr_offset  (read_addr_offset),
        .swap_done         (swap_done),
        .shadow_ready      (shadow_ready),
        .load_err          (load_err)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    always @(posedge write_clk) cyc++;

    // Monitor: every write strobe and every swap_done is matched in order against the scoreboard
    always @(negedge write_clk) begin
        if (rstn) begin
            if (we) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: got write page=%0d, expected no write", page_write_addr);
                end else begin
                    me = exp_q.pop_front();
                    if (me.is_swap || int'(page_write_addr) != me.pg || int'(lut_in_bank0) != me.b0 ||
                        int'(lut_in_bank1) != me.b1 || int'(write_addr_offset) != me.ofs) begin
                        n_fail++;
                        $display("FAIL wr_check: got page=%0d b0=%0d b1=%0d ofs=%0d, expected swap=%0d page=%0d b0=%0d b1=%0d ofs=%0d",
                                 page_write_addr, lut_in_bank0, lut_in_bank1, write_addr_offset,
                                 me.is_swap, me.pg, me.b0, me.b1, me.ofs);
                    end
                end
                last_we_cyc = cyc;
            end
            if (swap_done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL swap_unexpected: got swap_done rd=%0d, expected no swap", read_addr_offset);
                end else begin
                    me = exp_q.pop_front();
                    if (!me.is_swap || int'(read_addr_offset) != me.ofs ||
                        (me.gap >= 0 && (cyc - last_we_cyc) != me.gap)) begin
                        n_fail++;
                        $display("FAIL swap_check: got rd=%0d gap=%0d, expected swap=%0d rd=%0d gap=%0d",
                                 read_addr_offset, cyc - last_we_cyc, me.is_swap, me.ofs, me.gap);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge write_clk);
        #1;
    endtask

    task automatic push_swap(input int rd, input int gap);
        exp_t e;
        e.is_swap = 1'b1; e.pg = 0; e.b0 = 0; e.b1 = 0; e.ofs = rd; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Present one beat, wait (bounded) for acceptance, record the write it must produce
    task automatic send_beat(input logic [2*LPS-1:0] d, input int pg, input int ofs, input logic with_swap);
        exp_t e;
        int   n;
        e.is_swap = 1'b0; e.pg = pg; e.b0 = int'(d[LPS-1:0]); e.b1 = int'(d[2*LPS-1:LPS]);
        e.ofs = ofs; e.gap = -1;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        swap_req = with_swap;
`ifdef IB_LUT_LOAD_CHKSUM_EN
        chk_data = chk_flip ? ~(chk_acc ^ d) : (chk_acc ^ d);
`endif
        n = 0;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: got in_ready=0 for 20 cycles, expected 1");
            void'(exp_q.pop_back());
        end else begin
            tick(1);
`ifdef IB_LUT_LOAD_CHKSUM_EN
            chk_acc = chk_acc ^ d;
`endif
        end
        in_valid = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
`ifdef IB_LUT_LOAD_CHKSUM_EN
        chk_acc = '0;
`endif
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        swap_req   = 1'b0;
`ifdef IB_LUT_LOAD_CHKSUM_EN
        chk_data = '0;
        chk_acc  = '0;
        chk_flip = 1'b0;
`endif
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_page", page_write_addr, 0);
        chk("rst_bank0", lut_in_bank0, 0);
        chk("rst_bank1", lut_in_bank1, 0);
        chk("rst_rd_ofs", read_addr_offset, 0);
        chk("rst_wr_ofs", write_addr_offset, 1);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_shadow", shadow_ready, 0);
        chk("rst_load_err", load_err, 0);
        tick(2);
        rstn = 1'b1;
        tick(1);

        // 1: back-to-back load into half 1
        pulse_start();
        chk("t1_in_ready", in_ready, 1);
        for (int i = 0; i < PN; i++) send_beat((2*LPS)'(i), i, 1, 1'b0);
        chk("t1_in_ready_drop", in_ready, 0);
        chk("t1_shadow", shadow_ready, 1);
        tick(2);
        chk("t1_shadow_hold", shadow_ready, 1);
        chk("t1_rd_ofs", read_addr_offset, 0);
        chk("t1_load_err", load_err, 0);

        // 2: swap request from READY
        push_swap(1, -1);
        pulse_swap();
        chk("t2_swap_done", swap_done, 1);
        chk("t2_rd_ofs", read_addr_offset, 1);
        chk("t2_wr_ofs", write_addr_offset, 0);
        chk("t2_shadow", shadow_ready, 0);
        tick(1);
        chk("t2_swap_done_drop", swap_done, 0);

        // 3: gapped beats into half 0; a load_start in READY is ignored
        pulse_start();
        for (int i = 0; i < PN; i++) begin
            send_beat((2*LPS)'(8 + i), i, 0, 1'b0);
            tick(1);
        end
        chk("t3_shadow", shadow_ready, 1);
        pulse_start();
        chk("t3_start_ignored_shadow", shadow_ready, 1);
        chk("t3_start_ignored_ready", in_ready, 0);
        push_swap(0, -1);
        pulse_swap();
        tick(1);

        // 4: swap_req on the last beat -> swap exactly one cycle after the last write
        pulse_start();
        for (int i = 0; i < PN - 1; i++) send_beat((2*LPS)'(15 - i), i, 1, 1'b0);
        send_beat((2*LPS)'(4'h6), PN - 1, 1, 1'b1);
        push_swap(1, 1);
        tick(3);
        chk("t4_rd_ofs", read_addr_offset, 1);
        chk("t4_idle", in_ready, 0);

        // 5: abort after 3 beats, pending swap must wait for the next complete load
        pulse_start();
        for (int i = 0; i < 3; i++) send_beat((2*LPS)'(i + 3), i, 0, 1'b0);
        load_abort = 1'b1;
        tick(1);
        load_abort = 1'b0;
        chk("t5_abort_idle", in_ready, 0);
        pulse_swap();
        pulse_swap();
        tick(4);
        chk("t5_no_swap_rd", read_addr_offset, 1);
        chk("t5_no_shadow", shadow_ready, 0);
        pulse_start();
        for (int i = 0; i < PN; i++) send_beat((2*LPS)'(i * 3), i, 0, 1'b0);
        push_swap(0, 1);
        tick(4);
        chk("t5_rd_after", read_addr_offset, 0);
        chk("t5_single_swap_shadow", shadow_ready, 0);
        chk("t5_single_swap_ready", in_ready, 0);

        // 6: reset while loading page 4
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat((2*LPS)'(i + 9), i, 1, 1'b0);
        tick(1);
        chk("t6_page_before", page_write_addr, 3);
        in_valid = 1'b1;
        in_data  = 4'hC;
        rstn     = 1'b0;
        #1;
        chk("t6_in_ready", in_ready, 0);
        chk("t6_we", we, 0);
        chk("t6_page", page_write_addr, 0);
        chk("t6_bank0", lut_in_bank0, 0);
        chk("t6_bank1", lut_in_bank1, 0);
        chk("t6_rd_ofs", read_addr_offset, 0);
        chk("t6_wr_ofs", write_addr_offset, 1);
        chk("t6_shadow", shadow_ready, 0);
        chk("t6_swap_done", swap_done, 0);
        in_valid = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(1);
        pulse_start();
        for (int i = 0; i < PN; i++) send_beat((2*LPS)'(i + 5), i, 1, 1'b0);
        tick(2);
        chk("t6_reload_shadow", shadow_ready, 1);

`ifdef IB_LUT_LOAD_CHKSUM_EN
        // Checksum: a bad final check word flags load_err and keeps the swap pending
        push_swap(1, -1);
        pulse_swap();
        tick(1);
        pulse_swap();
        pulse_start();
        for (int i = 0; i < PN; i++) begin
            chk_flip = (i == PN - 1);
            send_beat((2*LPS)'(i + 2), i, 0, 1'b0);
        end
        chk_flip = 1'b0;
        tick(3);
        chk("ck_load_err", load_err, 1);
        chk("ck_no_swap_rd", read_addr_offset, 1);
        chk("ck_no_shadow", shadow_ready, 0);
        pulse_start();
        chk("ck_err_cleared", load_err, 0);
        for (int i = 0; i < PN; i++) send_beat((2*LPS)'(i + 1), i, 0, 1'b0);
        push_swap(0, 1);
        tick(4);
        chk("ck_swap_rd", read_addr_offset, 0);
`endif

        tick(3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
